// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Load-use stall, taken-branch flush and memory-freeze sequencing
//            for a 5-stage MIPS pipeline, with stall/flush statistics and a
//            freeze watchdog.
// Revision : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W      = 16,
    parameter int FREEZE_MAX = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ifid_instr,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             exmem_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             pipe_hold,
    output logic             ctl_bubble,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             freeze_timeout
);

    localparam logic [1:0] c_RUN    = 2'd0;
    localparam logic [1:0] c_STALL  = 2'd1;
    localparam logic [1:0] c_FLUSH  = 2'd2;
    localparam logic [1:0] c_FREEZE = 2'd3;

    localparam int               c_FW       = $clog2(FREEZE_MAX + 1);
    localparam logic [c_FW-1:0]  c_FRZ_MAX  = c_FW'(FREEZE_MAX);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    logic [5:0]       w_op;
    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic             w_rt_is_src;
    logic             w_lu;
    logic [1:0]       w_next_state;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [c_FW-1:0]  r_frz_cnt;
    logic             r_timeout;

    assign w_op = ifid_instr[31:26];
    assign w_rs = ifid_instr[25:21];
    assign w_rt = ifid_instr[20:16];

    // rt is read only by R-type, beq, bne and sw; elsewhere it is a destination
    always_comb begin
        w_rt_is_src = 1'b0;
        case (w_op)
            6'h00, 6'h04, 6'h05, 6'h2B: w_rt_is_src = 1'b1;
            default:                    w_rt_is_src = 1'b0;
        endcase
    end

    assign w_lu = idex_memread && (idex_rt != 5'd0) &&
                  ((idex_rt == w_rs) || ((idex_rt == w_rt) && w_rt_is_src));

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        pipe_hold    = 1'b0;
        ctl_bubble   = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        flush_exmem  = 1'b0;
        w_next_state = c_RUN;
        if (rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ctl_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            pipe_hold    = 1'b1;
            w_next_state = c_FREEZE;
        end else if (exmem_branch_taken) begin
            flush_ifid   = 1'b1;
            flush_idex   = 1'b1;
            flush_exmem  = 1'b1;
            w_next_state = c_FLUSH;
        end else if (w_lu) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ctl_bubble   = 1'b1;
            w_next_state = c_STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_frz_cnt   <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (mem_busy) begin
                // Count parks at FREEZE_MAX; the next busy cycle would exceed it
                if (r_frz_cnt == c_FRZ_MAX)
                    r_timeout <= 1'b1;
                else
                    r_frz_cnt <= r_frz_cnt + c_FW'(1);
            end else begin
                r_frz_cnt <= '0;
            end
            if (w_next_state == c_FLUSH && r_flush_cnt != c_CNT_MAX)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            if (w_next_state == c_STALL && r_stall_cnt != c_CNT_MAX)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign state          = r_state;
    assign stall_count    = r_stall_cnt;
    assign flush_count    = r_flush_cnt;
    assign freeze_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed plus random checking of hazard_ctrl against a
//            cycle-level reference model of the hazard priority rules.
// Revision : 1.0
// ============================================================================
module tb_hazard_ctrl;

    localparam int CNT_W      = 2;
    localparam int FREEZE_MAX = 4;
    localparam int CNT_SAT    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      ifid_instr;
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic             exmem_branch_taken;
    logic             mem_busy;
    logic             pc_write, ifid_write, pipe_hold, ctl_bubble;
    logic             flush_ifid, flush_idex, flush_exmem;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count, flush_count;
    logic             freeze_timeout;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_state = 0, m_stall = 0, m_flush = 0, m_run = 0;
    bit m_to = 0;

    hazard_ctrl #(.CNT_W(CNT_W), .FREEZE_MAX(FREEZE_MAX)) dut (
        .clk(clk), .rst(rst), .ifid_instr(ifid_instr),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .exmem_branch_taken(exmem_branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .pipe_hold(pipe_hold),
        .ctl_bubble(ctl_bubble), .flush_ifid(flush_ifid),
        .flush_idex(flush_idex), .flush_exmem(flush_exmem), .state(state),
        .stall_count(stall_count), .flush_count(flush_count),
        .freeze_timeout(freeze_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_lu(input logic mr, input logic [4:0] rt, input logic [31:0] ins);
        int op, rs, irt;
        bit src;
        op  = int'(ins[31:26]);
        rs  = int'(ins[25:21]);
        irt = int'(ins[20:16]);
        src = (op == 0) || (op == 4) || (op == 5) || (op == 43);
        return mr && (rt != 0) && (int'(rt) == rs || (int'(rt) == irt && src));
    endfunction

    // One clock: check combinational controls, take the edge, check registers
    task automatic cyc(input logic r, input logic busy, input logic br,
                       input logic mr, input logic [4:0] rt, input logic [31:0] ins);
        bit lu;
        logic [6:0] exp_ctl;
        rst = r; mem_busy = busy; exmem_branch_taken = br;
        idex_memread = mr; idex_rt = rt; ifid_instr = ins;
        #1;
        lu = model_lu(mr, rt, ins);
        // {pc_write, ifid_write, pipe_hold, ctl_bubble, flush_ifid, flush_idex, flush_exmem}
        if (r)         exp_ctl = 7'b0001000;
        else if (busy) exp_ctl = 7'b0010000;
        else if (br)   exp_ctl = 7'b1100111;
        else if (lu)   exp_ctl = 7'b0001000;
        else           exp_ctl = 7'b1100000;
        chk("controls", 32'({pc_write, ifid_write, pipe_hold, ctl_bubble,
                             flush_ifid, flush_idex, flush_exmem}), 32'(exp_ctl));
        @(posedge clk);
        if (r) begin
            m_state = 0; m_stall = 0; m_flush = 0; m_run = 0; m_to = 0;
        end else if (busy) begin
            m_state = 3;
            m_run++;
            if (m_run > FREEZE_MAX) m_to = 1;
        end else begin
            m_run = 0;
            if (br) begin
                m_state = 2;
                if (m_flush < CNT_SAT) m_flush++;
            end else if (lu) begin
                m_state = 1;
                if (m_stall < CNT_SAT) m_stall++;
            end else begin
                m_state = 0;
            end
        end
        #1;
        chk("state", 32'(state), 32'(m_state));
        chk("stall_count", 32'(stall_count), 32'(m_stall));
        chk("flush_count", 32'(flush_count), 32'(m_flush));
        chk("freeze_timeout", 32'(freeze_timeout), 32'(m_to));
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 5'd0, 32'h0000_0020);
    endtask

    initial begin
        logic [5:0] ops [6];
        ops[0] = 6'h00; ops[1] = 6'h04; ops[2] = 6'h05;
        ops[3] = 6'h2B; ops[4] = 6'h08; ops[5] = 6'h23;

        cyc(1, 0, 0, 0, 5'd0, 32'h0);
        cyc(1, 1, 1, 1, 5'd14, 32'h01C3_4020);
        chk("reset_state", 32'(state), 32'd0);

        // load-use on rs
        cyc(0, 0, 0, 1, 5'd14, 32'h01C3_4020);
        chk("lu_rs_state", 32'(state), 32'd1);
        chk("lu_rs_count", 32'(stall_count), 32'd1);
        idle();
        chk("lu_no_restall", 32'(state), 32'd0);

        // rt source rules
        cyc(0, 0, 0, 1, 5'd14, 32'hAC6E_0000);
        chk("sw_rt_stall", 32'(state), 32'd1);
        cyc(0, 0, 0, 1, 5'd14, 32'h206E_0001);
        chk("addi_rt_nostall", 32'(state), 32'd0);
        cyc(0, 0, 0, 1, 5'd0, 32'h0000_0020);
        chk("rt0_nostall", 32'(state), 32'd0);

        // branch beats load-use
        cyc(0, 0, 1, 1, 5'd14, 32'h01C3_4020);
        chk("br_lu_flush_count", 32'(flush_count), 32'd1);
        chk("br_lu_stall_count", 32'(stall_count), 32'd2);

        // freeze holds a pending branch
        repeat (3) begin
            cyc(0, 1, 1, 0, 5'd0, 32'h0);
            chk("freeze_state", 32'(state), 32'd3);
        end
        cyc(0, 0, 1, 0, 5'd0, 32'h0);
        chk("freeze_release_flush", 32'(state), 32'd2);

        // watchdog
        repeat (FREEZE_MAX) cyc(0, 1, 0, 0, 5'd0, 32'h0);
        chk("wd_at_max", 32'(freeze_timeout), 32'd0);
        idle();
        repeat (FREEZE_MAX + 1) cyc(0, 1, 0, 0, 5'd0, 32'h0);
        chk("wd_over_max", 32'(freeze_timeout), 32'd1);
        idle();
        chk("wd_sticky", 32'(freeze_timeout), 32'd1);
        cyc(1, 1, 0, 1, 5'd14, 32'h01C3_4020);
        chk("wd_rst_flag", 32'(freeze_timeout), 32'd0);
        chk("wd_rst_flush", 32'(flush_count), 32'd0);

        // stall counter saturation
        repeat (5) begin
            cyc(0, 0, 0, 1, 5'd14, 32'h01C3_4020);
            idle();
        end
        chk("stall_saturate", 32'(stall_count), 32'(CNT_SAT));

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 5)];
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0), 1'($urandom),
                5'($urandom_range(0, 3)), ins);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
